// File: rtl/irq_ctrl_pkg.sv
// Shared definitions for the memory-mapped interrupt controller:
// register offsets within the 16-byte window and FSM state encoding.
package irq_ctrl_pkg;

  localparam logic [3:0] IRQ_ACK  = 4'h0;
  localparam logic [3:0] IRQ_MASK = 4'h4;
  localparam logic [3:0] IRQ_PEND = 4'h8;
  localparam logic [3:0] IRQ_STAT = 4'hC;

  // Encoding is software-visible through STATUS[5:4].
  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,
    ST_ASSERT = 2'd1,
    ST_GAP    = 2'd2
  } irq_state_e;

endpackage

// File: rtl/irq_ctrl_if.sv
// Data-bus slice seen by the interrupt controller (CPU M-stage address/store
// lanes in, combinational read data out).
interface irq_ctrl_if;
  logic [31:0] m_addr;
  logic [31:0] m_wdata;
  logic [3:0]  m_byteen;
  logic [31:0] m_rdata;

  modport master (output m_addr, m_wdata, m_byteen, input m_rdata);
  modport slave  (input m_addr, m_wdata, m_byteen, output m_rdata);
endinterface

// File: rtl/irq_prio_enc.sv
// Combinational priority encoder: reports whether any bit is set and the
// index of the lowest set bit.
module irq_prio_enc #(
  parameter int N = 6
) (
  input  logic [N-1:0] vec,
  output logic         any,
  output logic [3:0]   idx
);

  // Scan from the top so the lowest set index is the last one written.
  always_comb begin
    any = 1'b0;
    idx = 4'd0;
    for (int i = N - 1; i >= 0; i--) begin
      if (vec[i]) begin
        any = 1'b1;
        idx = 4'(i);
      end
    end
  end

endmodule

// File: rtl/irq_ctrl.sv
// Interrupt controller: edge-latched pending bits, mask, lowest-index
// arbitration and a held interrupt line released by a store to ACK.
module irq_ctrl
  import irq_ctrl_pkg::*;
#(
  parameter int          N_SRC = 6,
  parameter logic [31:0] BASE  = 32'h7F20
) (
  input  logic             clk,
  input  logic             reset,
  input  logic [N_SRC-1:0] irq_src,
  irq_ctrl_if.slave        bus,
  output logic             irq_out,
  output logic [3:0]       irq_id
);

  irq_state_e       state, state_nxt;
  logic [3:0]       id_nxt;
  logic [N_SRC-1:0] src_q, pending, mask;
  logic [N_SRC-1:0] edge_v, be_bits, wdata_n, w1c, ack_clr, req, mask_new;
  logic             hit, wr, ack_wr, mask_wr, pend_wr, ack_now, req_any;
  logic [3:0]       off, req_idx;
  logic             unused_bits;

  assign hit     = bus.m_addr[31:4] == BASE[31:4];
  assign off     = {bus.m_addr[3:2], 2'b00};
  assign wr      = hit && (bus.m_byteen != 4'h0);
  assign ack_wr  = wr && (off == IRQ_ACK);
  assign mask_wr = wr && (off == IRQ_MASK);
  assign pend_wr = wr && (off == IRQ_PEND);
  assign ack_now = ack_wr && (state == ST_ASSERT);

  for (genvar g = 0; g < N_SRC; g++) begin : g_be
    assign be_bits[g] = bus.m_byteen[g/8];
  end

  assign wdata_n     = bus.m_wdata[N_SRC-1:0];
  assign unused_bits = ^{bus.m_addr[1:0], bus.m_wdata[31:N_SRC]};

  assign edge_v   = irq_src & ~src_q;
  assign w1c      = pend_wr ? (wdata_n & be_bits) : '0;
  assign ack_clr  = ack_now ? (N_SRC'(1) << irq_id) : '0;
  assign mask_new = (mask & ~be_bits) | (wdata_n & be_bits);
  assign req      = pending & mask;

  irq_prio_enc #(.N(N_SRC)) u_prio (
    .vec (req),
    .any (req_any),
    .idx (req_idx)
  );

  // src_q keeps sampling through reset so a level held across reset is not an edge.
  always_ff @(posedge clk) src_q <= irq_src;

  // A new edge overrides both software clears in the same cycle.
  always_ff @(posedge clk) begin
    if (reset) begin
      pending <= '0;
      mask    <= '0;
    end else begin
      pending <= (pending & ~w1c & ~ack_clr) | edge_v;
      if (mask_wr) mask <= mask_new;
    end
  end

  always_comb begin
    state_nxt = state;
    id_nxt    = irq_id;
    unique case (state)
      ST_IDLE: begin
        if (req_any) begin
          state_nxt = ST_ASSERT;
          id_nxt    = req_idx;
        end
      end
      ST_ASSERT: if (ack_now) state_nxt = ST_GAP;
      ST_GAP:    state_nxt = ST_IDLE;
      default:   state_nxt = ST_IDLE;
    endcase
  end

  // irq_out comes straight from a flop so CP0 never sees decode glitches.
  always_ff @(posedge clk) begin
    if (reset) begin
      state   <= ST_IDLE;
      irq_id  <= 4'd0;
      irq_out <= 1'b0;
    end else begin
      state   <= state_nxt;
      irq_id  <= id_nxt;
      irq_out <= (state_nxt == ST_ASSERT);
    end
  end

  always_comb begin
    bus.m_rdata = 32'h0;
    if (hit) begin
      unique case (off)
        IRQ_MASK: bus.m_rdata = 32'(mask);
        IRQ_PEND: bus.m_rdata = 32'(pending);
        IRQ_STAT: bus.m_rdata = {26'b0, state, irq_id};
        default:  bus.m_rdata = 32'h0;
      endcase
    end
  end

endmodule

// File: tb/tb_irq_ctrl.sv
// Bench for irq_ctrl: directed scenarios with constant expectations plus a
// randomized run checked against a cycle-level behavioural model.
module tb_irq_ctrl;

  localparam logic [31:0] A_ACK  = 32'h7F20;
  localparam logic [31:0] A_MASK = 32'h7F24;
  localparam logic [31:0] A_PEND = 32'h7F28;
  localparam logic [31:0] A_STAT = 32'h7F2C;

  logic       clk = 1'b0;
  logic       reset = 1'b1;
  logic [5:0] irq_src = 6'h0;
  logic       irq_out;
  logic [3:0] irq_id;
  int         checks = 0;
  int         errors = 0;

  irq_ctrl_if bus ();

  irq_ctrl #(.N_SRC(6), .BASE(32'h7F20)) dut (
    .clk     (clk),
    .reset   (reset),
    .irq_src (irq_src),
    .bus     (bus),
    .irq_out (irq_out),
    .irq_id  (irq_id)
  );

  always #5 clk = ~clk;

  // Reference model: pending/mask as plain bit sets, service as a flag plus a gap flag.
  bit [5:0] m_pend, m_mask, m_srcq;
  bit       m_serv, m_gap;
  bit [3:0] m_id;

  task automatic model_update();
    bit [5:0] edges, np, nm, req;
    bit       wr, ack;
    edges = irq_src & ~m_srcq;
    if (reset) begin
      m_pend = 0; m_mask = 0; m_serv = 0; m_gap = 0; m_id = 0;
    end else begin
      wr  = (bus.m_addr[31:4] == 28'h7F2) && (bus.m_byteen != 0);
      ack = wr && (bus.m_addr[3:2] == 2'd0);
      np  = m_pend;
      nm  = m_mask;
      for (int i = 0; i < 6; i++) begin
        if (wr && bus.m_addr[3:2] == 2'd2 && bus.m_byteen[i/8] && bus.m_wdata[i]) np[i] = 0;
        if (wr && bus.m_addr[3:2] == 2'd1 && bus.m_byteen[i/8]) nm[i] = bus.m_wdata[i];
      end
      if (ack && m_serv) np[m_id] = 0;
      np = np | edges;
      req = m_pend & m_mask;
      if (m_serv) begin
        if (ack) begin m_serv = 0; m_gap = 1; end
      end else if (m_gap) begin
        m_gap = 0;
      end else if (req != 0) begin
        for (int i = 5; i >= 0; i--) if (req[i]) m_id = 4'(i);
        m_serv = 1;
      end
      m_pend = np;
      m_mask = nm;
    end
    m_srcq = irq_src;
  endtask

  function automatic logic [31:0] model_read(logic [31:0] a);
    if (a[31:4] != 28'h7F2) return 32'h0;
    case (a[3:2])
      2'd1:    return {26'b0, m_mask};
      2'd2:    return {26'b0, m_pend};
      2'd3:    return {26'b0, (m_serv ? 2'd1 : (m_gap ? 2'd2 : 2'd0)), m_id};
      default: return 32'h0;
    endcase
  endfunction

  task automatic tick();
    @(posedge clk);
    model_update();
    #1;
  endtask

  task automatic store(input logic [31:0] a, input logic [31:0] d, input logic [3:0] be);
    bus.m_addr = a; bus.m_wdata = d; bus.m_byteen = be;
    tick();
    bus.m_byteen = 4'h0;
  endtask

  task automatic rd(input logic [31:0] a, output logic [31:0] d);
    bus.m_addr = a; bus.m_byteen = 4'h0;
    #1;
    d = bus.m_rdata;
  endtask

  task automatic wait_irq(input int n, output bit seen);
    seen = 0;
    for (int i = 0; i < n && !seen; i++) begin
      tick();
      seen = (irq_out === 1'b1);
    end
  endtask

  task automatic test_reset();
    logic [31:0] d;
    reset = 1'b1; tick(); tick(); reset = 1'b0;
    for (int c = 0; c < 10; c++) begin
      tick();
      checks++; if (irq_out !== 1'b0) begin errors++; $display("FAIL reset_irq_out got %b want 0", irq_out); end
      rd(A_MASK, d);
      checks++; if (d !== 32'h0) begin errors++; $display("FAIL reset_mask got %h want 0", d); end
      rd(A_PEND, d);
      checks++; if (d !== 32'h0) begin errors++; $display("FAIL reset_pend got %h want 0", d); end
      rd(A_STAT, d);
      checks++; if (d !== 32'h0) begin errors++; $display("FAIL reset_stat got %h want 0", d); end
    end
  endtask

  task automatic test_single();
    logic [31:0] d;
    bit seen;
    store(A_MASK, 32'h3F, 4'hF);
    irq_src[2] = 1'b1;
    tick();
    rd(A_PEND, d);
    checks++; if (d !== 32'h04) begin errors++; $display("FAIL single_pend got %h want 04", d); end
    wait_irq(2, seen);
    checks++; if (!seen) begin errors++; $display("FAIL single_latency irq_out got 0 want 1 within 3 cycles"); end
    checks++; if (irq_id !== 4'd2) begin errors++; $display("FAIL single_id got %0d want 2", irq_id); end
    store(A_ACK, 32'h0, 4'b0001);
    checks++; if (irq_out !== 1'b0) begin errors++; $display("FAIL single_gap got %b want 0", irq_out); end
    rd(A_PEND, d);
    checks++; if (d !== 32'h0) begin errors++; $display("FAIL single_pend_clr got %h want 0", d); end
    irq_src[2] = 1'b0;
    tick();
    checks++; if (irq_out !== 1'b0) begin errors++; $display("FAIL single_idle got %b want 0", irq_out); end
  endtask

  task automatic test_priority();
    logic [31:0] d;
    bit seen;
    irq_src[4] = 1'b1; irq_src[1] = 1'b1;
    wait_irq(3, seen);
    checks++; if (!seen || irq_id !== 4'd1) begin errors++; $display("FAIL prio_first irq_out %b id %0d want 1 id 1", irq_out, irq_id); end
    store(A_ACK, 32'h0, 4'hF);
    checks++; if (irq_out !== 1'b0) begin errors++; $display("FAIL prio_gap got %b want 0", irq_out); end
    wait_irq(3, seen);
    checks++; if (!seen || irq_id !== 4'd4) begin errors++; $display("FAIL prio_second irq_out %b id %0d want 1 id 4", irq_out, irq_id); end
    store(A_ACK, 32'h0, 4'hF);
    rd(A_PEND, d);
    checks++; if (d !== 32'h0) begin errors++; $display("FAIL prio_pend got %h want 0", d); end
    irq_src = 6'h0; tick(); tick();
  endtask

  task automatic test_mask_w1c();
    logic [31:0] d;
    bit seen;
    store(A_MASK, 32'h0, 4'hF);
    irq_src[3] = 1'b1;
    tick(); tick(); tick();
    rd(A_PEND, d);
    checks++; if (d !== 32'h08) begin errors++; $display("FAIL mask_pend got %h want 08", d); end
    checks++; if (irq_out !== 1'b0) begin errors++; $display("FAIL mask_blocked got %b want 0", irq_out); end
    store(A_MASK, 32'h08, 4'hF);
    wait_irq(3, seen);
    checks++; if (!seen || irq_id !== 4'd3) begin errors++; $display("FAIL mask_enable irq_out %b id %0d want 1 id 3", irq_out, irq_id); end
    store(A_PEND, 32'h08, 4'hF);
    tick(); tick();
    checks++; if (irq_out !== 1'b1) begin errors++; $display("FAIL w1c_hold got %b want 1", irq_out); end
    rd(A_PEND, d);
    checks++; if (d !== 32'h0) begin errors++; $display("FAIL w1c_pend got %h want 0", d); end
    store(A_ACK, 32'h0, 4'hF);
    checks++; if (irq_out !== 1'b0) begin errors++; $display("FAIL w1c_ack got %b want 0", irq_out); end
    irq_src = 6'h0; tick(); tick();
  endtask

  task automatic test_edge_vs_ack();
    logic [31:0] d;
    bit seen;
    store(A_MASK, 32'h01, 4'hF);
    irq_src[0] = 1'b1;
    wait_irq(3, seen);
    checks++; if (!seen || irq_id !== 4'd0) begin errors++; $display("FAIL race_first irq_out %b id %0d want 1 id 0", irq_out, irq_id); end
    irq_src[0] = 1'b0; tick();
    irq_src[0] = 1'b1;
    store(A_ACK, 32'h0, 4'hF);
    rd(A_PEND, d);
    checks++; if (d !== 32'h01) begin errors++; $display("FAIL race_pend got %h want 01", d); end
    checks++; if (irq_out !== 1'b0) begin errors++; $display("FAIL race_gap got %b want 0", irq_out); end
    wait_irq(3, seen);
    checks++; if (!seen || irq_id !== 4'd0) begin errors++; $display("FAIL race_reassert irq_out %b id %0d want 1 id 0", irq_out, irq_id); end
    store(A_ACK, 32'h0, 4'hF);
    irq_src = 6'h0; tick(); tick();
  endtask

  task automatic test_reset_mid_assert();
    logic [31:0] d;
    bit seen;
    store(A_MASK, 32'h3F, 4'hF);
    irq_src = 6'b000101;
    wait_irq(3, seen);
    rd(A_PEND, d);
    checks++; if (!seen || d !== 32'h05) begin errors++; $display("FAIL rst_setup irq_out %b pend %h want 1 pend 05", irq_out, d); end
    reset = 1'b1; tick();
    checks++; if (irq_out !== 1'b0) begin errors++; $display("FAIL rst_irq got %b want 0", irq_out); end
    rd(A_STAT, d);
    checks++; if (d !== 32'h0) begin errors++; $display("FAIL rst_stat got %h want 0", d); end
    rd(A_PEND, d);
    checks++; if (d !== 32'h0) begin errors++; $display("FAIL rst_pend got %h want 0", d); end
    reset = 1'b0;
    for (int c = 0; c < 3; c++) begin
      tick();
      rd(A_PEND, d);
      checks++; if (d !== 32'h0) begin errors++; $display("FAIL rst_held_src pend %h want 0", d); end
    end
    irq_src = 6'h0; tick();
  endtask

  task automatic test_random();
    logic [31:0] a, d, exp;
    for (int c = 0; c < 600; c++) begin
      int op;
      op = $urandom_range(0, 9);
      reset = ($urandom_range(0, 99) == 0);
      for (int b = 0; b < 6; b++) if ($urandom_range(0, 3) == 0) irq_src[b] = ~irq_src[b];
      a = (op == 9) ? 32'h7F30 : (32'h7F20 | ($urandom_range(0, 3) << 2) | $urandom_range(0, 3));
      bus.m_addr   = a;
      bus.m_wdata  = ($urandom_range(0, 1) == 0) ? $urandom : ($urandom & 32'h0000_0303);
      bus.m_byteen = (op < 4) ? 4'h0 : 4'($urandom_range(1, 15));
      #1;
      exp = model_read(a);
      d   = bus.m_rdata;
      checks++; if (d !== exp) begin errors++; $display("FAIL rand_rdata addr %h got %h want %h", a, d, exp); end
      tick();
      checks++; if (irq_out !== m_serv) begin errors++; $display("FAIL rand_irq_out cycle %0d got %b want %b", c, irq_out, m_serv); end
      if (m_serv) begin
        checks++; if (irq_id !== m_id) begin errors++; $display("FAIL rand_irq_id cycle %0d got %0d want %0d", c, irq_id, m_id); end
      end
    end
    reset = 1'b0; bus.m_byteen = 4'h0; irq_src = 6'h0;
    tick(); tick();
  endtask

  initial begin
    bus.m_addr = 32'h0; bus.m_wdata = 32'h0; bus.m_byteen = 4'h0;
    test_reset();
    test_single();
    test_priority();
    test_mask_w1c();
    test_edge_vs_ack();
    test_reset_mid_assert();
    test_random();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
